rv_reg_scoreboard: RTL and testbench

//  Issue-side hazard controller for the 2R/1W register file (registered reads, 1-cycle latency, x0 = 0).

---
 rtl/rv_reg_scoreboard.sv | 100 ++++++++++
 tb/tb_rv_reg_scoreboard.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rv_reg_scoreboard.sv
// Issue-side hazard controller for the 2R/1W register file: tracks pending long-latency
// writes, stalls dependent issue and produces read-during-write forwarding selects.
module rv_reg_scoreboard #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STALL_CNT_W     = 32
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_issue_valid,
    output logic                   o_issue_ready,
    input  logic                   i_flush,
    input  logic [4:0]             i_rs1,
    input  logic [4:0]             i_rs2,
    input  logic                   i_rs1_used,
    input  logic                   i_rs2_used,
    input  logic [4:0]             i_rd,
    input  logic                   i_rd_long,
    input  logic                   i_wb_write,
    input  logic [4:0]             i_wb_rd,
    input  logic [31:0]            i_wb_data,
    input  logic                   i_wb_long,
    output logic                   o_fwd1,
    output logic                   o_fwd2,
    output logic [31:0]            o_fwd_data,
    output logic [31:0]            o_pending,
    output logic [3:0]             o_outstanding,
    output logic [STALL_CNT_W-1:0] o_stall_cnt
);

    localparam logic [3:0] MaxOut = 4'(MAX_OUTSTANDING);

    logic [31:0]            pending_q, pending_d;
    logic [3:0]             outstanding_q, outstanding_d;
    logic                   fwd1_q, fwd2_q;
    logic [31:0]            fwdData_q;
    logic [STALL_CNT_W-1:0] stallCnt_q, stallCnt_d;

    logic wbLong, clr1, clr2, clrRd;
    logic hz1, hz2, waw, full, ready, accept, incOut;

    // A completing long write releases its register in the same cycle, so a dependent may issue.
    always_comb begin
        wbLong = i_wb_write & i_wb_long;
        clr1   = wbLong & (i_rs1 == i_wb_rd) & (i_rs1 != 5'd0);
        clr2   = wbLong & (i_rs2 == i_wb_rd) & (i_rs2 != 5'd0);
        clrRd  = wbLong & (i_rd == i_wb_rd) & (i_rd != 5'd0);
        hz1    = i_rs1_used & (i_rs1 != 5'd0) & pending_q[i_rs1] & ~clr1;
        hz2    = i_rs2_used & (i_rs2 != 5'd0) & pending_q[i_rs2] & ~clr2;
        waw    = i_rd_long & (i_rd != 5'd0) & pending_q[i_rd] & ~clrRd;
        full   = i_rd_long & (outstanding_q == MaxOut) & ~wbLong;
        ready  = ~hz1 & ~hz2 & ~waw & ~full & ~i_flush;
        accept = i_issue_valid & ready;
        incOut = accept & i_rd_long;
    end

    always_comb begin
        pending_d = pending_q;
        if (wbLong && i_wb_rd != 5'd0) pending_d[i_wb_rd] = 1'b0;
        if (incOut && i_rd != 5'd0) pending_d[i_rd] = 1'b1;

        outstanding_d = outstanding_q;
        if (incOut && !wbLong) outstanding_d = outstanding_q + 4'd1;
        else if (!incOut && wbLong && outstanding_q != 4'd0) outstanding_d = outstanding_q - 4'd1;

        stallCnt_d = stallCnt_q;
        if (i_issue_valid && !ready && !i_flush && stallCnt_q != {STALL_CNT_W{1'b1}})
            stallCnt_d = stallCnt_q + STALL_CNT_W'(1);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            pending_q     <= '0;
            outstanding_q <= '0;
            fwd1_q        <= 1'b0;
            fwd2_q        <= 1'b0;
            fwdData_q     <= '0;
            stallCnt_q    <= '0;
        end else begin
            pending_q     <= pending_d;
            outstanding_q <= outstanding_d;
            fwd1_q        <= i_wb_write & (i_wb_rd != 5'd0) & (i_wb_rd == i_rs1);
            fwd2_q        <= i_wb_write & (i_wb_rd != 5'd0) & (i_wb_rd == i_rs2);
            if (i_wb_write) fwdData_q <= i_wb_data;
            stallCnt_q    <= stallCnt_d;
        end
    end

    // A long completion with nothing in flight indicates a broken producer.
    assert property (@(posedge i_clk) disable iff (!i_reset_n)
        !(wbLong && !incOut && outstanding_q == 4'd0));

    assign o_issue_ready = ready;
    assign o_fwd1        = fwd1_q;
    assign o_fwd2        = fwd2_q;
    assign o_fwd_data    = fwdData_q;
    assign o_pending     = pending_q;
    assign o_outstanding = outstanding_q;
    assign o_stall_cnt   = stallCnt_q;

endmodule

// File: tb/tb_rv_reg_scoreboard.sv
// Directed bench for rv_reg_scoreboard; a second instance with a 4-bit stall counter
// shares the stimulus so that saturation is reachable in a short run.
module tb_rv_reg_scoreboard;

    logic        clk;
    logic        resetN;
    logic        issueValid, flush;
    logic [4:0]  rs1, rs2, rd, wbRd;
    logic        rs1Used, rs2Used, rdLong, wbWrite, wbLong;
    logic [31:0] wbData;

    logic        ready, fwd1, fwd2;
    logic [31:0] fwdData, pending, stallCnt;
    logic [3:0]  outstanding;

    logic        readyS, fwd1S, fwd2S;
    logic [31:0] fwdDataS, pendingS;
    logic [3:0]  outstandingS, stallCntS;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    rv_reg_scoreboard #(.MAX_OUTSTANDING(4), .STALL_CNT_W(32)) dut (
        .i_clk(clk), .i_reset_n(resetN), .i_issue_valid(issueValid), .o_issue_ready(ready),
        .i_flush(flush), .i_rs1(rs1), .i_rs2(rs2), .i_rs1_used(rs1Used), .i_rs2_used(rs2Used),
        .i_rd(rd), .i_rd_long(rdLong), .i_wb_write(wbWrite), .i_wb_rd(wbRd), .i_wb_data(wbData),
        .i_wb_long(wbLong), .o_fwd1(fwd1), .o_fwd2(fwd2), .o_fwd_data(fwdData),
        .o_pending(pending), .o_outstanding(outstanding), .o_stall_cnt(stallCnt)
    );

    rv_reg_scoreboard #(.MAX_OUTSTANDING(4), .STALL_CNT_W(4)) dutSmall (
        .i_clk(clk), .i_reset_n(resetN), .i_issue_valid(issueValid), .o_issue_ready(readyS),
        .i_flush(flush), .i_rs1(rs1), .i_rs2(rs2), .i_rs1_used(rs1Used), .i_rs2_used(rs2Used),
        .i_rd(rd), .i_rd_long(rdLong), .i_wb_write(wbWrite), .i_wb_rd(wbRd), .i_wb_data(wbData),
        .i_wb_long(wbLong), .o_fwd1(fwd1S), .o_fwd2(fwd2S), .o_fwd_data(fwdDataS),
        .o_pending(pendingS), .o_outstanding(outstandingS), .o_stall_cnt(stallCntS)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle's inputs (applied 1 time unit after a rising edge, checked before the next).
    task automatic applyStimulus(input logic valid, input logic [4:0] s1, input logic u1,
                                 input logic [4:0] s2, input logic u2, input logic [4:0] d,
                                 input logic dLong, input logic wWrite, input logic [4:0] wRd,
                                 input logic [31:0] wData, input logic wLong, input logic fl);
        issueValid = valid; rs1 = s1; rs1Used = u1; rs2 = s2; rs2Used = u2;
        rd = d; rdLong = dLong; wbWrite = wWrite; wbRd = wRd; wbData = wData;
        wbLong = wLong; flush = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetN = 1'b0;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        tick();
        tick();

        // Reset state, with issue_valid held high throughout
        checkOutput("rst_pending", pending, 32'h0);
        checkOutput("rst_outstanding", {28'h0, outstanding}, 32'h0);
        checkOutput("rst_fwd1", {31'h0, fwd1}, 32'h0);
        checkOutput("rst_fwd2", {31'h0, fwd2}, 32'h0);
        checkOutput("rst_fwd_data", fwdData, 32'h0);
        checkOutput("rst_stall_cnt", stallCnt, 32'h0);
        resetN = 1'b1;
        #1;
        checkOutput("rst_ready", {31'h0, ready}, 32'h1);
        tick();

        // Load to x5, dependent add stalls until the load writes back
        applyStimulus(1, 0, 0, 0, 0, 5, 1, 0, 0, 32'h0, 0, 0);
        checkOutput("load_ready", {31'h0, ready}, 32'h1);
        tick();
        checkOutput("load_pending", pending, 32'h0000_0020);
        checkOutput("load_outstanding", {28'h0, outstanding}, 32'h1);
        applyStimulus(1, 5, 1, 0, 0, 6, 0, 0, 0, 32'h0, 0, 0);
        checkOutput("raw_ready", {31'h0, ready}, 32'h0);
        tick();
        checkOutput("raw_stall1", stallCnt, 32'h1);
        tick();
        checkOutput("raw_stall2", stallCnt, 32'h2);
        applyStimulus(1, 5, 1, 0, 0, 6, 0, 1, 5, 32'hDEAD_BEEF, 1, 0);
        checkOutput("wb_clear_ready", {31'h0, ready}, 32'h1);
        tick();
        checkOutput("wb_fwd1", {31'h0, fwd1}, 32'h1);
        checkOutput("wb_fwd2", {31'h0, fwd2}, 32'h0);
        checkOutput("wb_fwd_data", fwdData, 32'hDEAD_BEEF);
        checkOutput("wb_pending", pending, 32'h0);
        checkOutput("wb_outstanding", {28'h0, outstanding}, 32'h0);
        checkOutput("wb_stall_held", stallCnt, 32'h2);

        // x0 never forwards or becomes pending
        applyStimulus(0, 0, 1, 0, 1, 0, 0, 1, 0, 32'h0000_1234, 0, 0);
        tick();
        checkOutput("x0_fwd1", {31'h0, fwd1}, 32'h0);
        checkOutput("x0_fwd_data", fwdData, 32'h0000_1234);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 0, 0);
        checkOutput("x0_long_ready", {31'h0, ready}, 32'h1);
        tick();
        checkOutput("x0_long_pending", pending, 32'h0);
        checkOutput("x0_long_outstanding", {28'h0, outstanding}, 32'h1);
        applyStimulus(0, 0, 0, 9, 1, 0, 0, 1, 0, 32'h0, 1, 0);
        tick();
        checkOutput("x0_drain_outstanding", {28'h0, outstanding}, 32'h0);
        applyStimulus(0, 0, 0, 9, 1, 0, 0, 1, 9, 32'h0000_55AA, 0, 0);
        tick();
        checkOutput("rs2_fwd2", {31'h0, fwd2}, 32'h1);
        checkOutput("rs2_fwd1", {31'h0, fwd1}, 32'h0);

        // Fill all four long slots, then a fifth waits for a completion
        for (int r = 1; r <= 4; r++) begin
            applyStimulus(1, 0, 0, 0, 0, 5'(r), 1, 0, 0, 32'h0, 0, 0);
            tick();
        end
        checkOutput("fill_outstanding", {28'h0, outstanding}, 32'h4);
        checkOutput("fill_pending", pending, 32'h0000_001E);
        applyStimulus(1, 0, 0, 0, 0, 8, 1, 0, 0, 32'h0, 0, 0);
        checkOutput("full_ready", {31'h0, ready}, 32'h0);
        tick();
        checkOutput("full_stall", stallCnt, 32'h3);
        applyStimulus(1, 0, 0, 0, 0, 8, 1, 1, 1, 32'h0000_0001, 1, 0);
        checkOutput("full_wb_ready", {31'h0, ready}, 32'h1);
        tick();
        checkOutput("full_wb_outstanding", {28'h0, outstanding}, 32'h4);
        checkOutput("full_wb_pending", pending, 32'h0000_011C);

        // Drain x2/x3, then same-cycle issue and completion on x7
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 2, 32'h2, 1, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h3, 1, 0);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 7, 1, 0, 0, 32'h0, 0, 0);
        tick();
        checkOutput("x7_pending", pending, 32'h0000_0190);
        checkOutput("x7_outstanding", {28'h0, outstanding}, 32'h3);
        applyStimulus(1, 0, 0, 0, 0, 7, 1, 1, 7, 32'h7, 1, 0);
        checkOutput("x7_same_ready", {31'h0, ready}, 32'h1);
        tick();
        checkOutput("x7_same_pending", pending, 32'h0000_0190);
        checkOutput("x7_same_outstanding", {28'h0, outstanding}, 32'h3);

        // Flush during a stall freezes the counter but completions still land
        applyStimulus(1, 4, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        tick();
        checkOutput("pre_flush_stall", stallCnt, 32'h4);
        applyStimulus(1, 4, 1, 0, 0, 0, 0, 1, 4, 32'h4, 1, 1);
        checkOutput("flush_ready", {31'h0, ready}, 32'h0);
        tick();
        checkOutput("flush_stall", stallCnt, 32'h4);
        checkOutput("flush_pending", pending, 32'h0000_0180);
        checkOutput("flush_outstanding", {28'h0, outstanding}, 32'h2);

        // Twelve rs2 stalls: wide counter reaches 16, 4-bit counter sticks at 15
        applyStimulus(1, 0, 0, 8, 1, 0, 0, 0, 0, 32'h0, 0, 0);
        checkOutput("hz2_ready", {31'h0, ready}, 32'h0);
        for (int i = 0; i < 12; i++) tick();
        checkOutput("sat_wide", stallCnt, 32'd16);
        checkOutput("sat_small", {28'h0, stallCntS}, 32'h0000_000F);

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 7, 32'h7, 1, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 8, 32'h8, 1, 0);
        tick();
        checkOutput("end_pending", pending, 32'h0);
        checkOutput("end_outstanding", {28'h0, outstanding}, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
